regfile_readback: RTL and testbench

- Register file with one write port, two combinational read ports, and a readback engine that streams a range of registers out over a valid/ready handshake.
- The write side is the existing register/enable/reset path. The readback side is the reader end, used by debug dump and by the bench to check architectural state.
- Sits beside the datapath register file in the lab CPU.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_readback_if.sv | 37 +++
 rtl/regfile_core.sv | 40 ++++
 rtl/regfile_readback.sv | 103 ++++++++++
 tb/tb_regfile_readback.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the readback register file.
// Holds default widths, the readback FSM state encoding and address wrap.
package regfile_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t SEND = 1'b1;

    function automatic logic [ADDR_W_DEF-1:0] wrap_inc(input logic [ADDR_W_DEF-1:0] addr);
        return addr + ADDR_W_DEF'(1);
    endfunction

endpackage

// File: rtl/regfile_readback_if.sv
// Write/read/stream bundle between the register file block and its user.
// Stream side is valid/ready; the consumer stalls the stream by dropping out_ready.
interface regfile_readback_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              wr_enable;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [WIDTH-1:0]  out_data;
    logic              busy;
    logic              done;

    modport master (
        output wr_enable, wr_addr, wr_data, rd_addr_a, rd_addr_b,
               start, start_addr, count, out_ready,
        input  rd_data_a, rd_data_b, out_valid, out_addr, out_data, busy, done
    );

    modport slave (
        input  wr_enable, wr_addr, wr_data, rd_addr_a, rd_addr_b,
               start, start_addr, count, out_ready,
        output rd_data_a, rd_data_b, out_valid, out_addr, out_data, busy, done
    );
endinterface

// File: rtl/regfile_core.sv
// Register array with one write port and three combinational read ports; reg 0 is hardwired to 0.
// Writes land at the clock edge; reads are zero-latency and never stall.
module regfile_core
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_enable,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    input  logic [ADDR_W-1:0] i_rd_addr_c,
    output logic [WIDTH-1:0]  o_rd_data_a,
    output logic [WIDTH-1:0]  o_rd_data_b,
    output logic [WIDTH-1:0]  o_rd_data_c
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_regs [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_enable && (i_wr_addr != '0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // No write forwarding: a same-cycle write shows up only after the edge.
    assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
    assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];
    assign o_rd_data_c = (i_rd_addr_c == '0) ? '0 : r_regs[i_rd_addr_c];

endmodule

// File: rtl/regfile_readback.sv
// Register file plus a readback engine streaming a wrapping address range; first word valid 1 cycle after start.
// Presented word is a held snapshot while out_ready is low; full rate is 1 word/cycle with no bubbles.
module regfile_readback
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    regfile_readback_if.slave  bus
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] REM_FULL = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_ptr_next;
    logic [ADDR_W-1:0] w_rd_addr_c;
    logic [WIDTH-1:0]  w_rd_data_c;
    logic              w_xfer;

    assign w_ptr_next  = wrap_inc(r_ptr);
    assign w_xfer      = r_out_valid && bus.out_ready;
    // Third port looks at whichever word the next capture would take.
    assign w_rd_addr_c = (r_state == IDLE) ? bus.start_addr : w_ptr_next;

    regfile_core #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .i_wr_enable (bus.wr_enable),
        .i_wr_addr   (bus.wr_addr),
        .i_wr_data   (bus.wr_data),
        .i_rd_addr_a (bus.rd_addr_a),
        .i_rd_addr_b (bus.rd_addr_b),
        .i_rd_addr_c (w_rd_addr_c),
        .o_rd_data_a (bus.rd_data_a),
        .o_rd_data_b (bus.rd_data_b),
        .o_rd_data_c (w_rd_data_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_ptr       <= bus.start_addr;
                        r_remaining <= (bus.count == '0) ? REM_FULL : bus.count;
                        r_out_addr  <= bus.start_addr;
                        r_out_data  <= w_rd_data_c;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (r_remaining == REM_ONE) begin
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_ptr       <= w_ptr_next;
                            r_remaining <= r_remaining - REM_ONE;
                            r_out_addr  <= w_ptr_next;
                            r_out_data  <= w_rd_data_c;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_regfile_readback.sv
// Directed bench for regfile_readback: expected stream words queue up at start and are
// retired by a negedge monitor at every valid/ready handshake.
module tb_regfile_readback;
    import regfile_pkg::*;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } word_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    word_t       sb_q[$];
    logic [31:0] mdl [32];

    regfile_readback_if bus ();

    regfile_readback dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.wr_enable = 1'b1;
        bus.wr_addr   = a;
        bus.wr_data   = d;
        step();
        bus.wr_enable = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    task automatic push_range(input logic [4:0] a, input int n);
        logic [4:0] p;
        p = a;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({p, (p == 5'd0) ? 32'd0 : mdl[p]});
            p = p + 5'd1;
        end
    endtask

    task automatic start_stream(input logic [4:0] a, input logic [5:0] n);
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.count      = n;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, {31'd0, bus.done}, 32'd1);
    endtask

    // Handshake completes at the next rising edge; retire the expected word now.
    always @(negedge clk) begin
        if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_word", {27'd0, bus.out_addr}, 32'hFFFF_FFFF);
            end else begin
                word_t w;
                w = sb_q.pop_front();
                check("stream_addr", {27'd0, bus.out_addr}, {27'd0, w.addr});
                check("stream_data", bus.out_data, w.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        reset          = 1'b1;
        bus.wr_enable  = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_addr_a  = 5'd7;
        bus.rd_addr_b  = 5'd0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.count      = '0;
        bus.out_ready  = 1'b1;
        step();
        reset = 1'b0;
        check("reset_rd_a7", bus.rd_data_a, 32'd0);
        check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);

        // Write port, no forwarding, enable gating, reg 0 hardwiring.
        bus.wr_enable = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'd88; bus.rd_addr_a = 5'd3;
        #1;
        check("no_forward", bus.rd_data_a, 32'd0);
        step();
        bus.wr_enable = 1'b0; mdl[3] = 32'd88;
        check("write_r3", bus.rd_data_a, 32'd88);
        bus.wr_data = 32'd89;
        step();
        check("wr_en_low", bus.rd_data_a, 32'd88);
        bus.rd_addr_b = 5'd0;
        wr(5'd0, 32'd42);
        check("reg0_b", bus.rd_data_b, 32'd0);

        // Back-to-back stream of 4 words.
        wr(5'd5, 32'd50); wr(5'd6, 32'd60); wr(5'd7, 32'd70); wr(5'd8, 32'd80);
        push_range(5'd5, 4);
        start_stream(5'd5, 6'd4);
        check("b2b_valid0", {31'd0, bus.out_valid}, 32'd1);
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
            check("b2b_done_low", {31'd0, bus.done}, 32'd0);
        end
        step();
        check("b2b_done", {31'd0, bus.done}, 32'd1);
        check("b2b_busy_end", {31'd0, bus.busy}, 32'd0);
        check("b2b_valid_end", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("b2b_done_pulse", {31'd0, bus.done}, 32'd0);
        check("b2b_sb_empty", sb_q.size(), 32'd0);

        // Backpressure with a write to the presented register.
        wr(5'd10, 32'd100); wr(5'd11, 32'd110);
        bus.out_ready = 1'b0;
        push_range(5'd10, 2);
        start_stream(5'd10, 6'd2);
        bus.wr_enable = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'd999;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_addr", {27'd0, bus.out_addr}, 32'd10);
            check("bp_data", bus.out_data, 32'd100);
        end
        bus.wr_enable = 1'b0; mdl[10] = 32'd999;
        bus.rd_addr_a = 5'd10;
        #1;
        check("bp_write_seen", bus.rd_data_a, 32'd999);
        bus.out_ready = 1'b1;
        step();
        check("bp_next_addr", {27'd0, bus.out_addr}, 32'd11);
        check("bp_next_data", bus.out_data, 32'd110);
        wait_done("bp_done", 5);
        check("bp_sb_empty", sb_q.size(), 32'd0);

        // Wrap past 31 and count==0 meaning a full sweep.
        wr(5'd30, 32'd300); wr(5'd31, 32'd310);
        push_range(5'd30, 3);
        start_stream(5'd30, 6'd3);
        wait_done("wrap_done", 10);
        check("wrap_sb_empty", sb_q.size(), 32'd0);
        step();
        push_range(5'd0, 32);
        start_stream(5'd0, 6'd0);
        wait_done("full_done", 40);
        check("full_sb_empty", sb_q.size(), 32'd0);
        step();

        // start while busy is ignored; start alongside done is accepted.
        push_range(5'd5, 3);
        start_stream(5'd5, 6'd3);
        bus.start = 1'b1; bus.start_addr = 5'd20; bus.count = 6'd1;
        step();
        bus.start = 1'b0;
        wait_done("ign_done", 10);
        check("ign_sb_empty", sb_q.size(), 32'd0);
        push_range(5'd3, 1);
        start_stream(5'd3, 6'd1);
        check("restart_valid", {31'd0, bus.out_valid}, 32'd1);
        check("restart_addr", {27'd0, bus.out_addr}, 32'd3);
        wait_done("restart_done", 5);
        check("restart_sb_empty", sb_q.size(), 32'd0);
        step();

        // Reset mid-stream aborts without done and clears the array.
        push_range(5'd5, 4);
        start_stream(5'd5, 6'd4);
        step();
        reset = 1'b1; bus.out_ready = 1'b0;
        step();
        reset = 1'b0; bus.out_ready = 1'b1;
        sb_q.delete();
        check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        step();
        check("abort_no_done", {31'd0, bus.done}, 32'd0);
        check("abort_idle", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr_a = 5'(i);
            #1;
            check("abort_reg_clear", bus.rd_data_a, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
